// File: rtl/bcd_down_counter_00_59_pkg.sv
// Shared constants and helpers for the two-digit BCD down-counter.
`ifndef BCD_WRAP_DEFAULT
`define BCD_WRAP_DEFAULT 1
`endif

package bcd_down_counter_00_59_pkg;

   localparam int unsigned DIGIT_W      = 4;
   localparam int unsigned BCD_ONES_MAX = 9;
   localparam int unsigned BCD_TENS_MAX = 5;
   localparam bit          WRAP_DEFAULT = `BCD_WRAP_DEFAULT;

   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                      input logic [DIGIT_W-1:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/syn_down_counter_4bit_with_load.sv
// One decimal digit: loadable down-counter that wraps to max_value_i or holds at zero.
module syn_down_counter_4bit_with_load
   import bcd_down_counter_00_59_pkg::*;
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               enable_i,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_value_i,
   input  logic [DIGIT_W-1:0] max_value_i,
   input  logic               wrap_en_i,
   output logic [DIGIT_W-1:0] q_o,
   output logic               borrow_o
);

   logic [DIGIT_W-1:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_value_i;
      end else if (enable_i) begin
         if (q_q != '0) begin
            q_d = q_q - DIGIT_W'(1);
         end else if (wrap_en_i) begin
            q_d = max_value_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o      = q_q;
   assign borrow_o = enable_i && (q_q == '0);

endmodule

// File: rtl/bcd_down_counter_00_59.sv
// Two-digit BCD down-counter (TENS_MAX:ONES_MAX down to 00) with preset load and borrow-out.
module bcd_down_counter_00_59
   import bcd_down_counter_00_59_pkg::*;
#(
   parameter int unsigned TENS_MAX = BCD_TENS_MAX,
   parameter int unsigned ONES_MAX = BCD_ONES_MAX,
   parameter bit          WRAP     = WRAP_DEFAULT
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               enable_i,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_tens_i,
   input  logic [DIGIT_W-1:0] load_ones_i,
   output logic [DIGIT_W-1:0] tens_o,
   output logic [DIGIT_W-1:0] ones_o,
   output logic               zero_o,
   output logic               borrow_o
);

   localparam logic [DIGIT_W-1:0] TensMaxC = DIGIT_W'(TENS_MAX);
   localparam logic [DIGIT_W-1:0] OnesMaxC = DIGIT_W'(ONES_MAX);

   logic [DIGIT_W-1:0] load_tens_c, load_ones_c;
   logic               ones_en, ones_borrow;
   logic               unused_tens_borrow;

   assign load_tens_c = clamp_digit(load_tens_i, TensMaxC);
   assign load_ones_c = clamp_digit(load_ones_i, OnesMaxC);

   // Without wrap the ones digit must not roll to ONES_MAX once the whole count is 00.
   assign ones_en = enable_i && (WRAP || !zero_o);

   syn_down_counter_4bit_with_load u_ones (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_i    (ones_en),
      .load_i      (load_i),
      .load_value_i(load_ones_c),
      .max_value_i (OnesMaxC),
      .wrap_en_i   (1'b1),
      .q_o         (ones_o),
      .borrow_o    (ones_borrow)
   );

   syn_down_counter_4bit_with_load u_tens (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_i    (ones_borrow),
      .load_i      (load_i),
      .load_value_i(load_tens_c),
      .max_value_i (TensMaxC),
      .wrap_en_i   (WRAP),
      .q_o         (tens_o),
      .borrow_o    (unused_tens_borrow)
   );

   assign zero_o   = (tens_o == '0) && (ones_o == '0);
   assign borrow_o = enable_i && zero_o;

endmodule
